// File: rtl/fft4_stream_ctrl.sv
// fft4_stream_ctrl: frame sequencer around a combinational 4-point FFT core.
// Collects 4 samples, holds them on core_f, captures the 4 bins one cycle
// later and streams them out in bin order with valid/ready backpressure.
// Optional feature macro: FFT4_FRAME_CNT_EN adds a 16-bit drained-frame counter.
module fft4_stream_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*N-1:0]       core_f,
  input  logic [4*(N+2)-1:0]   core_re,
  input  logic [4*(N+2)-1:0]   core_im,
  output logic [N+1:0]         out_re,
  output logic [N+1:0]         out_im,
  output logic [1:0]           out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef FFT4_FRAME_CNT_EN
  output logic [15:0]          frame_cnt,
`endif
  output logic                 busy
);

  localparam int unsigned BW = N + 2;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            w_accept;
  logic            w_take;
  logic [1:0]      r_ld_cnt;
  logic [1:0]      r_dr_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic [4*N-1:0]  r_core_f;
  logic [4*BW-1:0] r_res_re;
  logic [4*BW-1:0] r_res_im;
  logic [BW-1:0]   r_out_re;
  logic [BW-1:0]   r_out_im;
`ifdef FFT4_FRAME_CNT_EN
  logic [15:0]     r_frame_cnt;
`endif

  // Next-state decode and handshake qualification
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (in_valid && r_in_ready) begin
          w_accept = 1'b1;
          if (r_ld_cnt == 2'd3) w_state_nxt = S_CALC;
        end
      end
      S_CALC:  w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (r_out_valid && out_ready) begin
          w_take = 1'b1;
          if (r_dr_cnt == 2'd3) w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // State register plus registered status flags decoded from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_LOAD);
      r_out_valid <= (w_state_nxt == S_DRAIN);
      r_busy      <= (w_state_nxt != S_LOAD);
    end
  end

  // Sample collection: core_f only moves on an accepted sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ld_cnt <= 2'd0;
      r_core_f <= '0;
    end else if (w_accept) begin
      r_ld_cnt <= r_ld_cnt + 2'd1;
      for (int k = 0; k < 4; k++) begin
        if (r_ld_cnt == 2'(k)) r_core_f[k*N +: N] <= in_data;
      end
    end
  end

  // Bin capture at the end of S_CALC and in-order drain with held outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_re <= '0;
      r_res_im <= '0;
      r_out_re <= '0;
      r_out_im <= '0;
      r_dr_cnt <= 2'd0;
    end else if (r_state == S_CALC) begin
      r_res_re <= core_re;
      r_res_im <= core_im;
      r_out_re <= core_re[0 +: BW];
      r_out_im <= core_im[0 +: BW];
      r_dr_cnt <= 2'd0;
    end else if (w_take) begin
      r_dr_cnt <= r_dr_cnt + 2'd1;
      for (int k = 1; k < 4; k++) begin
        if (r_dr_cnt == 2'(k - 1)) begin
          r_out_re <= r_res_re[k*BW +: BW];
          r_out_im <= r_res_im[k*BW +: BW];
        end
      end
    end
  end

`ifdef FFT4_FRAME_CNT_EN
  // Count fully drained frames, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= 16'd0;
    end else if (w_take && (r_dr_cnt == 2'd3)) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign core_f    = r_core_f;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign out_idx   = r_dr_cnt;

endmodule

// File: tb/tb_fft4_stream_ctrl.sv
// Scoreboard bench for fft4_stream_ctrl with a behavioural 4-point DFT core.
module tb_fft4_stream_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned BW = N + 2;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      in_data;
  logic              in_valid;
  logic              in_ready;
  logic [4*N-1:0]    core_f;
  logic [4*BW-1:0]   core_re;
  logic [4*BW-1:0]   core_im;
  logic [BW-1:0]     out_re;
  logic [BW-1:0]     out_im;
  logic [1:0]        out_idx;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
`ifdef FFT4_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
`endif

  fft4_stream_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_f(core_f), .core_re(core_re), .core_im(core_im),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef FFT4_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: X[k] = sum f[n] * (-j)^(n*k)
  function automatic logic [8*BW-1:0] core_model(input logic [4*N-1:0] f);
    int cr[4];
    int ci[4];
    int re, im, m, s;
    logic [4*BW-1:0] vr, vi;
    cr = '{1, 0, -1, 0};
    ci = '{0, -1, 0, 1};
    vr = '0;
    vi = '0;
    for (int k = 0; k < 4; k++) begin
      re = 0;
      im = 0;
      for (int n = 0; n < 4; n++) begin
        s  = int'($signed(f[n*N +: N]));
        m  = (n * k) % 4;
        re += s * cr[m];
        im += s * ci[m];
      end
      vr[k*BW +: BW] = BW'(re);
      vi[k*BW +: BW] = BW'(im);
    end
    return {vr, vi};
  endfunction

  assign {core_re, core_im} = core_model(core_f);

  typedef struct {
    int           idx;
    int           re;
    int           im;
    logic [31:0]  cf;
  } exp_t;

  exp_t        q[$];
  longint      tq[$];
  int          vectors;
  int          miscompares;
  int          mode;
  int          stall_left;
  logic        prev_v;
  logic        chk_rdy;

  // Reference: closed-form bins of a real 4-point frame
  task automatic push_frame(input int f[4], input longint t_acc);
    int re[4];
    int im[4];
    logic [31:0] cf;
    exp_t e;
    re[0] = f[0] + f[1] + f[2] + f[3]; im[0] = 0;
    re[1] = f[0] - f[2];               im[1] = f[3] - f[1];
    re[2] = f[0] - f[1] + f[2] - f[3]; im[2] = 0;
    re[3] = f[0] - f[2];               im[3] = f[1] - f[3];
    for (int i = 0; i < 4; i++) cf[i*8 +: 8] = 8'(f[i]);
    for (int k = 0; k < 4; k++) begin
      e.idx = k; e.re = re[k]; e.im = im[k]; e.cf = cf;
      q.push_back(e);
    end
    tq.push_back(t_acc + 64'd15);
  endtask

  // Output consumer pacing
  always @(posedge clk) begin
    #1;
    case (mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (out_valid && out_idx == 2'd1 && stall_left > 0) begin
          out_ready  = 1'b0;
          stall_left = stall_left - 1;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: compare every valid output cycle against the scoreboard head
  always @(negedge clk) begin
    exp_t   e;
    longint et;
    if (!rst_n) begin
      prev_v  = 1'b0;
      chk_rdy = 1'b0;
    end else begin
      if (chk_rdy) begin
        vectors++;
        if (!(in_ready && !out_valid && !busy)) begin
          miscompares++;
          $display("FAIL post_drain: in_ready=%0b out_valid=%0b busy=%0b, required 1 0 0",
                   in_ready, out_valid, busy);
        end
        chk_rdy = 1'b0;
      end
      if (out_valid) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_bin: idx=%0d re=%0d, required no output", out_idx,
                   int'($signed(out_re)));
        end else begin
          e = q[0];
          if (int'(out_idx) != e.idx || int'($signed(out_re)) != e.re ||
              int'($signed(out_im)) != e.im || core_f != e.cf || in_ready || !busy) begin
            miscompares++;
            $display("FAIL bin: idx=%0d re=%0d im=%0d core_f=%h in_ready=%0b busy=%0b, required idx=%0d re=%0d im=%0d core_f=%h in_ready=0 busy=1",
                     out_idx, int'($signed(out_re)), int'($signed(out_im)), core_f, in_ready,
                     busy, e.idx, e.re, e.im, e.cf);
          end
          if (!prev_v) begin
            vectors++;
            et = (tq.size() != 0) ? tq.pop_front() : -64'sd1;
            if (longint'($time) != et) begin
              miscompares++;
              $display("FAIL latency: bin0 seen at %0t, required %0d", $time, et);
            end
          end
          if (out_ready) begin
            void'(q.pop_front());
            if (e.idx == 3) chk_rdy = 1'b1;
          end
        end
      end
      prev_v = out_valid;
    end
  end

  // Drive up to cnt samples of f, with random idle gaps; in_data churns while not ready
  task automatic send(input int f[4], input int cnt, input int gap_max);
    int     n;
    longint t_acc;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
        in_data = 8'($urandom);
        @(posedge clk); #1;
        n++;
      end
      if (n >= 200) begin
        vectors++;
        miscompares++;
        $display("FAIL in_ready_timeout: in_ready=%0b, required 1", in_ready);
      end
      in_data = 8'(f[i]);
      @(posedge clk);
      t_acc = longint'($time);
      #1;
      if (i == 3) push_frame(f, t_acc);
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= 1000) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d bins pending, required 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    tq.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int f[4];
    vectors     = 0;
    miscompares = 0;
    mode        = 0;
    stall_left  = 0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    prev_v      = 1'b0;
    chk_rdy     = 1'b0;

    // 1: reset values
    do_reset();
    vectors++;
    if (!(in_ready && !out_valid && !busy && core_f == '0 && out_re == '0 &&
          out_im == '0 && out_idx == 2'd0)) begin
      miscompares++;
      $display("FAIL reset: in_ready=%0b out_valid=%0b busy=%0b core_f=%h re=%h im=%h idx=%0d, required 1 0 0 0 0 0 0",
               in_ready, out_valid, busy, core_f, out_re, out_im, out_idx);
    end
`ifdef FFT4_FRAME_CNT_EN
    vectors++;
    if (frame_cnt != 16'd0) begin
      miscompares++;
      $display("FAIL reset_frame_cnt: %0d, required 0", frame_cnt);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2: basic frame, no stalls
    f = '{1, 2, 1, 0};
    send(f, 4, 0);
    wait_drain();

    // 3: most negative samples, full growth
    f = '{-128, -128, -128, -128};
    send(f, 4, 0);
    wait_drain();

    // 4: five-cycle stall on bin 1
    mode = 2;
    stall_left = 5;
    f = '{1, 2, 1, 0};
    send(f, 4, 0);
    wait_drain();
    mode = 0;

    // 5: gaps between samples
    f = '{1, 2, 1, 0};
    send(f, 4, 3);
    wait_drain();

    // 6: reset after two accepted samples, then a fresh frame
    f = '{1, 2, 1, 0};
    send(f, 2, 0);
    do_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    f = '{3, 3, 3, 3};
    send(f, 4, 0);
    wait_drain();
`ifdef FFT4_FRAME_CNT_EN
    vectors++;
    if (frame_cnt != 16'd1) begin
      miscompares++;
      $display("FAIL frame_cnt: %0d, required 1", frame_cnt);
    end
`endif

    // Random frames back to back with random consumer stalls
    mode = 1;
    for (int fr = 0; fr < 25; fr++) begin
      for (int i = 0; i < 4; i++) f[i] = $urandom_range(0, 255) - 128;
      send(f, 4, 2);
    end
    wait_drain();
    mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
